uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side sequencer for the UART. Detects the start bit on a 16x-oversampled
//  serial input and samples each bit at mid-bit. Shifts data in LSB-first, optionally
//  checks parity, then checks the stop bit. Presents the frame as RX_out with a
//  one-cycle RX_valid strobe; the frame is zeroed on a stop error. Sits between the
//  baud generator and the RX FIFO.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (5..8)
//  OVERSAMPLE  16  baud_tick pulses per bit period (even, >=8)
// PORTS
//  CLK           input   1          system clock, rising edge
//  RST           input   1          asynchronous reset, active-low
//  baud_tick     input   1          1-CLK pulse, OVERSAMPLE per bit period
//  RX_in         input   1          raw serial line, idle high
//  parity_en     input   1          1 = frame carries a parity bit
//  parity_odd    input   1          1 = odd parity, 0 = even
//  RX_out        output  DATA_BITS  received data, held until next frame completes
//  RX_valid      output  1          1-CLK strobe, frame done (RX_out/errors valid)
//  stop_error    output  1          stop bit sampled 0 on last frame
//  parity_error  output  1          parity mismatch on last frame (0 if parity_en=0)
//  busy          output  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset (RST=0, async): state=IDLE; sync flops=1; counters=0; RX_out=0;
//   RX_valid=0; stop_error=0; parity_error=0; busy=0.
//  RX_in passes through a 2-flop synchronizer (reset 1); rx_s = synced value.
//   All decisions use rx_s.
//  Counters advance only on baud_tick.
//   - os_cnt: 0..OVERSAMPLE-1, wraps.
//   - bit_cnt: 0..DATA_BITS-1.
//  FSM:
//   IDLE   : on baud_tick with rx_s=0 -> START, os_cnt=0.
//   START  : on the tick where os_cnt=OVERSAMPLE/2-1 (mid start bit), sample rx_s.
//            - rx_s=1: false start -> IDLE, no RX_valid.
//            - rx_s=0: -> DATA, os_cnt=0, bit_cnt=0.
//   DATA   : on the tick where os_cnt=OVERSAMPLE-1, shift rx_s into shreg MSB,
//            shifting right (LSB first).
//            - bit_cnt=DATA_BITS-1: -> PARITY if parity_en else STOP.
//            - otherwise bit_cnt++.
//   PARITY : on the tick where os_cnt=OVERSAMPLE-1, par_err = (^shreg ^ rx_s ^ parity_odd);
//            -> STOP.
//   STOP   : on the tick where os_cnt=OVERSAMPLE-1, sample rx_s; -> IDLE. On that CLK edge:
//            - stop_error <= ~rx_s
//            - parity_error <= parity_en & par_err
//            - RX_out <= ~rx_s ? 0 : shreg
//            - RX_valid <= 1 for exactly one CLK
//  parity_en and parity_odd are sampled at the START->DATA transition and held for
//   the frame; changes mid-frame have no effect.
//  Latency: RX_valid rises 1 CLK after the mid-stop-bit sampling tick.
//  Error flags and RX_out hold until the next RX_valid. A false start does not change them.
//  No baud_tick: FSM and counters frozen; RX_in edges are ignored in IDLE.
//  Break (line held 0): the frame completes with stop_error=1 and RX_out=0. FSM
//   returns to IDLE, then immediately re-enters START on the next tick because
//   rx_s=0. This repeats until the line returns high.
//  Reset mid-frame: abort immediately to IDLE; partial data is discarded.
// TESTING
//  1. 8N1 frame 0xA5, good stop -> 1 RX_valid pulse, RX_out=0xA5, stop_error=0,
//     parity_error=0.
//  2. 8N1 frame 0x3C, stop bit driven 0 -> RX_valid pulse, RX_out=0x00,
//     stop_error=1.
//  3. Even parity, 0x07 with parity bit 1 -> parity_error=0. Same frame with
//     parity bit 0 -> parity_error=1, RX_out=0x07.
//  4. 0-glitch of 4 ticks on idle line -> START then back to IDLE, no RX_valid,
//     prior RX_out unchanged.
//  5. Assert RST low during bit 4 of frame 0xFF, release, send 0x12 -> single
//     RX_valid with RX_out=0x12. busy=0 while in reset.
//  6. Back-to-back frames 0x55, 0xAA, no idle gap -> two RX_valid pulses ten bit
//     periods apart, values in order.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
// Bundle of signals between the UART receive sequencer and its neighbours:
// the baud generator (tick), the serial line, the frame configuration and
// the frame result presented towards the RX FIFO.
//   master : the side that feeds the sequencer (tick, line, config)
//   slave  : the receive sequencer itself
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    // Inputs to the sequencer
    logic                 baud_tick;     // 1-CLK pulse, OVERSAMPLE per bit
    logic                 RX_in;         // raw serial line, idle high
    logic                 parity_en;     // frame carries a parity bit
    logic                 parity_odd;    // 1 = odd parity, 0 = even

    // Outputs from the sequencer
    logic [DATA_BITS-1:0] RX_out;        // last received data word
    logic                 RX_valid;      // 1-CLK frame-done strobe
    logic                 stop_error;    // stop bit sampled low
    logic                 parity_error;  // parity mismatch
    logic                 busy;          // not in IDLE

    modport master (
        output baud_tick,
        output RX_in,
        output parity_en,
        output parity_odd,
        input  RX_out,
        input  RX_valid,
        input  stop_error,
        input  parity_error,
        input  busy
    );

    modport slave (
        input  baud_tick,
        input  RX_in,
        input  parity_en,
        input  parity_odd,
        output RX_out,
        output RX_valid,
        output stop_error,
        output parity_error,
        output busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side sequencer of the UART. The serial line is synchronised, a
// start bit is detected on the 16x (OVERSAMPLE) baud tick, and every bit is
// sampled at its middle. Data arrives LSB first, an optional parity bit is
// checked, then the stop bit. The finished frame is presented on RX_out with
// a single-cycle RX_valid strobe; a bad stop bit zeroes the presented word.
//
// Parameter range: DATA_BITS 5..8, OVERSAMPLE even and >= 8.
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic          CLK,
    input  logic          RST,     // asynchronous, active-low
    uart_rx_ctrl_if.slave bus
);

    // -----------------------------------------------------------------------
    // Local constants
    // -----------------------------------------------------------------------
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Tick on which the start bit is at its middle (counting from detection)
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    // Last tick of a bit period; every later bit is sampled here, which
    // lands one full bit period after the previous mid-bit sample
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    // XOR-reduction of the received data word (1 = odd number of ones)
    function automatic logic f_data_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    logic                 r_sync_1;
    logic                 r_sync_2;
    logic                 w_rx_s;
    logic                 w_tick;

    state_t               r_state;
    logic [OS_W-1:0]      r_os_cnt;
    logic [BC_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_par_en;      // parity_en held for the frame
    logic                 r_par_odd;     // parity_odd held for the frame
    logic                 r_par_err;     // parity result of this frame

    logic [DATA_BITS-1:0] r_rx_out;
    logic                 r_rx_valid;
    logic                 r_stop_error;
    logic                 r_parity_error;
    logic                 r_busy;

    assign w_rx_s = r_sync_2;
    assign w_tick = bus.baud_tick;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync_1 <= 1'b1;
            r_sync_2 <= 1'b1;
        end else begin
            r_sync_1 <= bus.RX_in;
            r_sync_2 <= r_sync_1;
        end
    end

    // Frame sequencer: state, oversample/bit counters, shift register and
    // the registered frame result; everything advances only on baud_tick
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state        <= ST_IDLE;
            r_os_cnt       <= '0;
            r_bit_cnt      <= '0;
            r_shreg        <= '0;
            r_par_en       <= 1'b0;
            r_par_odd      <= 1'b0;
            r_par_err      <= 1'b0;
            r_rx_out       <= '0;
            r_rx_valid     <= 1'b0;
            r_stop_error   <= 1'b0;
            r_parity_error <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            // Frame-done strobe lasts exactly one CLK
            r_rx_valid <= 1'b0;

            if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_rx_s) begin
                            r_state  <= ST_START;
                            r_os_cnt <= '0;
                            r_busy   <= 1'b1;
                        end else begin
                            r_os_cnt <= '0;
                        end
                    end

                    ST_START: begin
                        if (r_os_cnt == OS_MID) begin
                            r_os_cnt <= '0;
                            if (w_rx_s) begin
                                // Line went back high: glitch, not a frame
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state   <= ST_DATA;
                                r_bit_cnt <= '0;
                                r_par_en  <= bus.parity_en;
                                r_par_odd <= bus.parity_odd;
                                r_par_err <= 1'b0;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + OS_ONE;
                        end
                    end

                    ST_DATA: begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt <= '0;
                            // LSB first: new bit enters at the MSB, shift right
                            r_shreg  <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                            if (r_bit_cnt == BC_LAST) begin
                                r_state <= r_par_en ? ST_PARITY : ST_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BC_ONE;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + OS_ONE;
                        end
                    end

                    ST_PARITY: begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt  <= '0;
                            r_par_err <= f_data_parity(r_shreg) ^ w_rx_s ^ r_par_odd;
                            r_state   <= ST_STOP;
                        end else begin
                            r_os_cnt <= r_os_cnt + OS_ONE;
                        end
                    end

                    ST_STOP: begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt       <= '0;
                            r_state        <= ST_IDLE;
                            r_busy         <= 1'b0;
                            r_stop_error   <= ~w_rx_s;
                            r_parity_error <= r_par_en & r_par_err;
                            // A framing error must not leak a bogus word downstream
                            r_rx_out       <= w_rx_s ? r_shreg : '0;
                            r_rx_valid     <= 1'b1;
                        end else begin
                            r_os_cnt <= r_os_cnt + OS_ONE;
                        end
                    end

                    default: begin
                        // Unreachable encoding: recover to a clean idle
                        r_state  <= ST_IDLE;
                        r_os_cnt <= '0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.RX_out       = r_rx_out;
    assign bus.RX_valid     = r_rx_valid;
    assign bus.stop_error   = r_stop_error;
    assign bus.parity_error = r_parity_error;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for the UART receive sequencer. baud_tick fires every 4 CLK,
// so one bit period is 16 ticks = 64 CLK and a 10-bit frame is 640 CLK.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DB       = 8;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic CLK = 1'b0;
    logic RST;
    logic tick_r = 1'b0;

    uart_rx_ctrl_if #(.DATA_BITS(DB)) u_if ();

    uart_rx_ctrl #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (16)
    ) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if.slave)
    );

    assign u_if.baud_tick = tick_r;

    // 100 MHz-style clock
    always #5 CLK = ~CLK;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int tick_ph   = 0;
    int valid_cnt = 0;
    int valid_cyc[$];
    logic [7:0] valid_dat[$];

    // Baud tick generation and RX_valid monitor, on the falling edge
    always @(negedge CLK) begin
        cyc     = cyc + 1;
        tick_ph = (tick_ph == TICK_DIV - 1) ? 0 : tick_ph + 1;
        tick_r  = (tick_ph == 0);
        if (u_if.RX_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc.push_back(cyc);
            valid_dat.push_back(u_if.RX_out);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        u_if.RX_in = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic use_par,
                              input logic par_bit, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(data[i]);
        if (use_par) send_bit(par_bit);
        send_bit(stop_bit);
    endtask

    int v0;
    int base;
    logic [31:0] d0, d1, gap;

    initial begin
        RST             = 1'b0;
        u_if.RX_in      = 1'b1;
        u_if.parity_en  = 1'b0;
        u_if.parity_odd = 1'b0;

        // ---------------- reset state ----------------
        wait_clks(3);
        check_eq("rst_rx_out",   32'(u_if.RX_out),       32'h00);
        check_eq("rst_valid",    32'(u_if.RX_valid),     32'h0);
        check_eq("rst_stop_err", 32'(u_if.stop_error),   32'h0);
        check_eq("rst_par_err",  32'(u_if.parity_error), 32'h0);
        check_eq("rst_busy",     32'(u_if.busy),         32'h0);
        RST = 1'b1;
        wait_clks(2 * BIT_CLKS);

        // ---------------- 1: 8N1 0xA5 good ----------------
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check_eq("t1_valid_cnt", 32'(valid_cnt - v0),    32'd1);
        check_eq("t1_rx_out",    32'(u_if.RX_out),       32'hA5);
        check_eq("t1_stop_err",  32'(u_if.stop_error),   32'h0);
        check_eq("t1_par_err",   32'(u_if.parity_error), 32'h0);
        check_eq("t1_busy_idle", 32'(u_if.busy),         32'h0);
        wait_clks(2 * BIT_CLKS);

        // ---------------- 2: 8N1 0x3C, stop bit 0 ----------------
        v0 = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_eq("t2_valid_cnt", 32'(valid_cnt - v0),  32'd1);
        check_eq("t2_rx_out",    32'(u_if.RX_out),     32'h00);
        check_eq("t2_stop_err",  32'(u_if.stop_error), 32'h1);
        u_if.RX_in = 1'b1;
        wait_clks(3 * BIT_CLKS);
        // trailing low stop bit retriggers START, which must die as a false start
        check_eq("t2_no_extra",  32'(valid_cnt - v0),  32'd1);
        check_eq("t2_err_held",  32'(u_if.stop_error), 32'h1);

        // ---------------- 3: parity ----------------
        u_if.parity_en  = 1'b1;
        u_if.parity_odd = 1'b0;
        v0 = valid_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        check_eq("t3_even_ok_cnt", 32'(valid_cnt - v0),    32'd1);
        check_eq("t3_even_ok_pe",  32'(u_if.parity_error), 32'h0);
        check_eq("t3_even_ok_se",  32'(u_if.stop_error),   32'h0);
        check_eq("t3_even_ok_out", 32'(u_if.RX_out),       32'h07);
        wait_clks(BIT_CLKS);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check_eq("t3_even_bad_pe",  32'(u_if.parity_error), 32'h1);
        check_eq("t3_even_bad_out", 32'(u_if.RX_out),       32'h07);
        wait_clks(BIT_CLKS);
        u_if.parity_odd = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check_eq("t3_odd_ok_pe", 32'(u_if.parity_error), 32'h0);
        wait_clks(BIT_CLKS);
        // config change after the start bit must not affect this frame
        u_if.parity_odd = 1'b0;
        v0 = valid_cnt;
        send_bit(1'b0);
        u_if.parity_en  = 1'b0;
        u_if.parity_odd = 1'b1;
        for (int i = 0; i < DB; i++) send_bit(1'(8'h07 >> i));
        send_bit(1'b0);   // parity bit, wrong for even parity
        send_bit(1'b1);   // stop bit
        check_eq("t3_held_cnt", 32'(valid_cnt - v0),    32'd1);
        check_eq("t3_held_pe",  32'(u_if.parity_error), 32'h1);
        check_eq("t3_held_se",  32'(u_if.stop_error),   32'h0);
        check_eq("t3_held_out", 32'(u_if.RX_out),       32'h07);
        u_if.parity_en  = 1'b0;
        u_if.parity_odd = 1'b0;
        wait_clks(2 * BIT_CLKS);

        // ---------------- 4: 4-tick glitch ----------------
        v0 = valid_cnt;
        u_if.RX_in = 1'b0;
        wait_clks(4 * TICK_DIV);
        check_eq("t4_busy_start", 32'(u_if.busy), 32'h1);
        u_if.RX_in = 1'b1;
        wait_clks(3 * BIT_CLKS);
        check_eq("t4_busy_idle", 32'(u_if.busy),         32'h0);
        check_eq("t4_no_valid",  32'(valid_cnt - v0),    32'd0);
        check_eq("t4_out_held",  32'(u_if.RX_out),       32'h07);
        check_eq("t4_pe_held",   32'(u_if.parity_error), 32'h1);

        // ---------------- 5: reset mid-frame ----------------
        v0 = valid_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        u_if.RX_in = 1'b1;          // bit 4 of 0xFF
        wait_clks(BIT_CLKS / 2);
        check_eq("t5_busy_pre", 32'(u_if.busy), 32'h1);
        RST = 1'b0;
        wait_clks(2);
        check_eq("t5_busy_rst",   32'(u_if.busy),         32'h0);
        check_eq("t5_out_rst",    32'(u_if.RX_out),       32'h00);
        check_eq("t5_pe_rst",     32'(u_if.parity_error), 32'h0);
        wait_clks(BIT_CLKS / 2);
        RST = 1'b1;
        wait_clks(2 * BIT_CLKS);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        check_eq("t5_valid_cnt", 32'(valid_cnt - v0),  32'd1);
        check_eq("t5_rx_out",    32'(u_if.RX_out),     32'h12);
        check_eq("t5_stop_err",  32'(u_if.stop_error), 32'h0);
        wait_clks(2 * BIT_CLKS);

        // ---------------- 6: back-to-back frames ----------------
        v0   = valid_cnt;
        base = valid_dat.size();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
        check_eq("t6_valid_cnt", 32'(valid_cnt - v0), 32'd2);
        d0  = (valid_dat.size() > base)     ? 32'(valid_dat[base])     : 32'hDEAD;
        d1  = (valid_dat.size() > base + 1) ? 32'(valid_dat[base + 1]) : 32'hDEAD;
        gap = (valid_cyc.size() > base + 1) ? 32'(valid_cyc[base + 1] - valid_cyc[base]) : 32'hDEAD;
        check_eq("t6_first",  d0,  32'h55);
        check_eq("t6_second", d1,  32'hAA);
        check_eq("t6_gap",    gap, 32'(10 * BIT_CLKS));
        check_eq("t6_stop_err", 32'(u_if.stop_error), 32'h0);
        wait_clks(BIT_CLKS);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
